// File: rtl/dlx_clock_ctrl_pkg.sv
// dlx_clock_ctrl_pkg: shared state encoding and default sizing for the DLX clock controller
package dlx_clock_ctrl_pkg;
  localparam int ClockPeriod = 10;
  localparam int DEF_RESET_CYCLES = 8;
  localparam int DEF_CNT_W = 32;
  localparam logic [1:0] ST_HOLD = 2'd0;
  localparam logic [1:0] ST_HALTED = 2'd1;
  localparam logic [1:0] ST_RUN = 2'd2;
  localparam logic [1:0] ST_STEP = 2'd3;
endpackage

// File: rtl/dlx_cycle_counter.sv
// dlx_cycle_counter: CNT_W-bit advance counter with clear and next-value breakpoint compare
//   clk, reset_n : clock, async active-low reset
//   en_i, clr_i  : count enable, synchronous clear (clear wins over enable)
//   target_i     : breakpoint target
//   count_o      : current count
//   match_o      : high when count_o + 1 == target_i (wraps modulo 2^CNT_W)
module dlx_cycle_counter
  import dlx_clock_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] target_i,
  output logic [CNT_W-1:0] count_o,
  output logic             match_o
);
  logic [CNT_W-1:0] count_q, count_d, count_inc;
  assign count_inc = count_q + CNT_W'(1);
  assign count_d = clr_i ? '0 : en_i ? count_inc : count_q;
  assign match_o = count_inc == target_i;
  assign count_o = count_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else count_q <= count_d;
  end
endmodule

// File: rtl/dlx_clock_ctrl.sv
// dlx_clock_ctrl: reset hold and run/halt/step clock-enable sequencer for the DLX core
//   clk, reset_n         : free-running clock, async active-low reset
//   dbg_run/halt/step/clr: one-cycle debug command pulses
//   brk_en, brk_count    : cycle-count breakpoint enable and target
//   core_rst_n           : registered active-low reset to the core
//   cpu_ce               : pipeline advance enable (RUN or STEP)
//   halted               : high in HALTED
//   step_done, brk_hit   : one-cycle pulses in the first HALTED cycle after a step / breakpoint
//   cycle_count          : cpu_ce-high cycles since reset or clear
module dlx_clock_ctrl
  import dlx_clock_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int CNT_W = DEF_CNT_W,
  parameter bit START_HALTED = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             dbg_run,
  input  logic             dbg_halt,
  input  logic             dbg_step,
  input  logic             dbg_clr,
  input  logic             brk_en,
  input  logic [CNT_W-1:0] brk_count,
  output logic             core_rst_n,
  output logic             cpu_ce,
  output logic             halted,
  output logic             step_done,
  output logic             brk_hit,
  output logic [CNT_W-1:0] cycle_count
);
  localparam int HW = $clog2(RESET_CYCLES + 1);
  logic [1:0] state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic core_rst_q, step_done_q, brk_hit_q;
  logic hold_last, in_hold, match, brk;
  assign in_hold = state_q == ST_HOLD;
  assign hold_last = hold_q == HW'(RESET_CYCLES - 1);
  // RUN and STEP share bit 1, so cpu_ce comes straight off a state flop
  assign cpu_ce = state_q[1];
  assign halted = state_q == ST_HALTED;
  assign brk = cpu_ce & brk_en & match;
  assign core_rst_n = core_rst_q;
  assign step_done = step_done_q;
  assign brk_hit = brk_hit_q;
  dlx_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .en_i     (cpu_ce),
    .clr_i    (dbg_clr & ~in_hold),
    .target_i (brk_count),
    .count_o  (cycle_count),
    .match_o  (match)
  );
  always_comb begin
    hold_d = (in_hold && !hold_last) ? hold_q + HW'(1) : hold_q;
    state_d = in_hold ? (hold_last ? (START_HALTED ? ST_HALTED : ST_RUN) : ST_HOLD)
            : halted ? (dbg_halt ? ST_HALTED : dbg_step ? ST_STEP : dbg_run ? ST_RUN : ST_HALTED)
            : (state_q == ST_STEP) ? ST_HALTED
            : (dbg_halt | brk) ? ST_HALTED : ST_RUN;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_HOLD;
      hold_q <= '0;
      core_rst_q <= 1'b0;
      step_done_q <= 1'b0;
      brk_hit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      core_rst_q <= state_d != ST_HOLD;
      step_done_q <= state_q == ST_STEP;
      brk_hit_q <= brk;
    end
  end
endmodule

// File: tb/tb_dlx_clock_ctrl.sv
// tb_dlx_clock_ctrl: directed self-checking bench for dlx_clock_ctrl
module tb_dlx_clock_ctrl;
  import dlx_clock_ctrl_pkg::*;
  logic clk = 1'b0;
  logic reset_n;
  logic dbg_run, dbg_halt, dbg_step, dbg_clr, brk_en;
  logic [31:0] brk_count;
  logic core_rst_n, cpu_ce, halted, step_done, brk_hit;
  logic [31:0] cycle_count;
  logic w_run, w_halt, w_step, w_clr, w_brk_en;
  logic [3:0] w_brk_count;
  logic w_core_rst_n, w_cpu_ce, w_halted, w_step_done, w_brk_hit;
  logic [3:0] w_count;
  int n_checks = 0;
  int n_errors = 0;
  always #(ClockPeriod / 2) clk = ~clk;
  dlx_clock_ctrl #(.RESET_CYCLES(8), .CNT_W(32), .START_HALTED(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .dbg_run(dbg_run), .dbg_halt(dbg_halt), .dbg_step(dbg_step),
    .dbg_clr(dbg_clr), .brk_en(brk_en), .brk_count(brk_count), .core_rst_n(core_rst_n),
    .cpu_ce(cpu_ce), .halted(halted), .step_done(step_done), .brk_hit(brk_hit),
    .cycle_count(cycle_count)
  );
  dlx_clock_ctrl #(.RESET_CYCLES(3), .CNT_W(4), .START_HALTED(1'b1)) dut_w (
    .clk(clk), .reset_n(reset_n), .dbg_run(w_run), .dbg_halt(w_halt), .dbg_step(w_step),
    .dbg_clr(w_clr), .brk_en(w_brk_en), .brk_count(w_brk_count), .core_rst_n(w_core_rst_n),
    .cpu_ce(w_cpu_ce), .halted(w_halted), .step_done(w_step_done), .brk_hit(w_brk_hit),
    .cycle_count(w_count)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int pulses;
    int guard;
    reset_n = 1'b0;
    {dbg_run, dbg_halt, dbg_step, dbg_clr, brk_en} = '0;
    brk_count = '0;
    {w_run, w_halt, w_step, w_clr, w_brk_en} = '0;
    w_brk_count = '0;
    #12;
    check("rst_core_rst_n", core_rst_n, 0);
    check("rst_cpu_ce", cpu_ce, 0);
    check("rst_halted", halted, 0);
    check("rst_count", cycle_count, 0);
    check("rst_step_done", step_done, 0);
    check("rst_brk_hit", brk_hit, 0);
    tick();
    reset_n = 1'b1;
    dbg_run = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("hold_core_rst_n", core_rst_n, 0);
      check("hold_cpu_ce", cpu_ce, 0);
    end
    dbg_run = 1'b0;
    tick();
    check("hold_exit_core_rst_n", core_rst_n, 1);
    check("hold_exit_cpu_ce", cpu_ce, 1);
    check("first_run_count", cycle_count, 0);
    repeat (5) tick();
    check("run_count5", cycle_count, 5);
    repeat (15) tick();
    check("run_count20", cycle_count, 20);
    dbg_halt = 1'b1;
    tick();
    dbg_halt = 1'b0;
    check("halt_cpu_ce", cpu_ce, 0);
    check("halt_halted", halted, 1);
    check("halt_count", cycle_count, 21);
    tick();
    check("halt_count_hold", cycle_count, 21);
    dbg_step = 1'b1;
    tick();
    dbg_step = 1'b0;
    check("step_cpu_ce", cpu_ce, 1);
    check("step_step_done_early", step_done, 0);
    tick();
    check("step_done_cpu_ce", cpu_ce, 0);
    check("step_count", cycle_count, 22);
    check("step_done_pulse", step_done, 1);
    tick();
    check("step_done_clear", step_done, 0);
    check("step_count_hold", cycle_count, 22);
    dbg_step = 1'b1;
    dbg_run = 1'b1;
    tick();
    {dbg_step, dbg_run} = '0;
    check("steprun_cpu_ce", cpu_ce, 1);
    tick();
    check("steprun_halted", halted, 1);
    tick();
    check("steprun_count", cycle_count, 23);
    check("steprun_cpu_ce_off", cpu_ce, 0);
    dbg_clr = 1'b1;
    tick();
    dbg_clr = 1'b0;
    check("clr_count", cycle_count, 0);
    brk_en = 1'b1;
    brk_count = 100;
    dbg_run = 1'b1;
    tick();
    dbg_run = 1'b0;
    check("brk_run_start", cycle_count, 0);
    pulses = 0;
    guard = 0;
    while (!halted && guard < 300) begin
      pulses += int'(brk_hit);
      tick();
      guard++;
    end
    check("brk_reached", halted, 1);
    check("brk_count_stop", cycle_count, 100);
    check("brk_hit_pulse", brk_hit, 1);
    pulses += int'(brk_hit);
    dbg_run = 1'b1;
    tick();
    dbg_run = 1'b0;
    pulses += int'(brk_hit);
    check("brk_hit_once", pulses, 1);
    tick();
    check("brk_resume_ce", cpu_ce, 1);
    check("brk_resume_count", cycle_count, 101);
    dbg_halt = 1'b1;
    dbg_clr = 1'b1;
    tick();
    {dbg_halt, dbg_clr} = '0;
    check("haltclr_halted", halted, 1);
    check("haltclr_count", cycle_count, 0);
    brk_count = 1;
    dbg_step = 1'b1;
    tick();
    dbg_step = 1'b0;
    tick();
    check("stepbrk_count", cycle_count, 1);
    check("stepbrk_step_done", step_done, 1);
    check("stepbrk_brk_hit", brk_hit, 1);
    check("stepbrk_halted", halted, 1);
    brk_en = 1'b0;
    dbg_run = 1'b1;
    tick();
    dbg_run = 1'b0;
    repeat (49) tick();
    check("midrst_count50", cycle_count, 50);
    reset_n = 1'b0;
    #1;
    check("midrst_cpu_ce", cpu_ce, 0);
    check("midrst_core_rst_n", core_rst_n, 0);
    check("midrst_count", cycle_count, 0);
    tick();
    reset_n = 1'b1;
    repeat (7) tick();
    check("midrst_hold7", core_rst_n, 0);
    check("w_start_halted", w_halted, 1);
    check("w_start_cpu_ce", w_cpu_ce, 0);
    tick();
    check("midrst_release", core_rst_n, 1);
    check("midrst_restart_count", cycle_count, 0);
    check("w_core_rst_n", w_core_rst_n, 1);
    check("w_count0", w_count, 0);
    w_run = 1'b1;
    tick();
    w_run = 1'b0;
    repeat (14) tick();
    check("w_count14", w_count, 14);
    w_brk_en = 1'b1;
    w_brk_count = 4'd2;
    tick();
    check("w_count15", w_count, 15);
    tick();
    check("w_wrap0", w_count, 0);
    tick();
    check("w_count1", w_count, 1);
    check("w_ce_before_brk", w_cpu_ce, 1);
    tick();
    check("w_brk_count", w_count, 2);
    check("w_brk_halted", w_halted, 1);
    check("w_brk_hit", w_brk_hit, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
